// File: rtl/fsm_serial_tx.sv
// fsm_serial_tx: framed serial byte transmitter with a one-entry holding register for gapless frames
module fsm_serial_tx #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_byte,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t     state;
    logic [7:0] hold;
    logic [7:0] shift;
    logic       hold_full;
    logic [2:0] cnt;
    logic       last_stop;
    assign ready     = resetn && !hold_full;
    assign busy      = state != IDLE;
    assign last_stop = cnt == 3'(STOP_BITS - 1);
    assign done      = state == STOP && last_stop;
    // holding register load plus frame sequencing; the hold is only loaded while empty and only unloaded while full
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            out       <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            cnt       <= '0;
        end else begin
            if (valid && ready) begin
                hold      <= in_byte;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    out <= 1'b1;
                    if (hold_full) begin
                        state     <= START;
                        out       <= 1'b0;
                        shift     <= hold;
                        hold_full <= 1'b0;
                    end
                end
                START: begin
                    state <= DATA;
                    out   <= shift[0];
                    shift <= shift >> 1;
                    cnt   <= '0;
                end
                DATA: begin
                    if (cnt == 3'd7) begin
                        state <= STOP;
                        out   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        out   <= shift[0];
                        shift <= shift >> 1;
                        cnt   <= cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (!last_stop) begin
                        cnt <= cnt + 3'd1;
                    end else if (hold_full) begin
                        state     <= START;
                        out       <= 1'b0;
                        shift     <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        state <= IDLE;
                        out   <= 1'b1;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/fsm_serial_tx.md
# fsm_serial_tx

Serial byte transmitter for the single-wire, one-bit-per-clock framed line used by the codebase's serial receiver FSM. Each byte goes out as one start bit (0), eight data bits LSB first, and STOP_BITS stop bits (1); the line idles at 1. A one-entry holding register lets the transmitter accept the next byte during a frame, so consecutive frames are sent with no idle gap, which the receiver's DONE→B0 path supports. The block sits between a byte producer with a valid/ready handshake and the serial pin.

## Interface
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous reset, active low.
- in_byte  input  8  byte to send; sampled only when valid && ready.
- valid  input  1  producer has a byte on in_byte.
- ready  output  1  holding register empty; equals !hold_full, and is forced to 0 while resetn is low.
- out  output  1  serial line, registered.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  high for exactly the cycle(s) out carries the final stop bit of a frame.

## Operation
- Holding register: loaded at a clock edge where valid && ready; hold_full is set at that edge. hold_full clears at the edge where its byte moves into the shift register. No load and unload can happen at the same edge, because ready is 0 while hold_full is 1.
- FSM states and out value per state:
  - IDLE: out = 1.
  - START: out = 0.
  - DATA: out = shift[0]; 3-bit counter runs 0..7.
  - STOP: out = 1; counter runs 0..STOP_BITS-1.
- Transitions:
  - IDLE → START when hold_full. Shift register ← hold.
  - START → DATA.
  - DATA: shift right each cycle. After bit 7, go to STOP.
  - STOP: on the last stop bit, go to START if hold_full (shift ← hold), otherwise go to IDLE.
- done = (state == STOP) && (stop counter == STOP_BITS-1).
- Reset (resetn sampled low):
  - State ← IDLE, out ← 1, hold_full ← 0, counters ← 0, shift ← 0.
  - A frame in progress is truncated and the line returns to 1 at that edge.
  - A byte in the holding register is discarded.
- While valid && !ready, in_byte changes are ignored. The producer must hold in_byte until the handshake completes.

## Timing
- Accept at edge N while IDLE:
  - START is entered at edge N+1; out = 0 from edge N+1 to N+2.
  - Data bit k is on out from edge N+2+k; bit 0 at N+2, bit 7 at N+9.
  - Stop bit(s) start at edge N+10.
  - With STOP_BITS = 1: returns to IDLE at edge N+11 if hold is empty.
- Frame length: 10 cycles (STOP_BITS = 1) or 11 cycles (STOP_BITS = 2).
- Back-to-back: the next start bit follows the last stop bit directly, so sustained throughput is one byte per frame length.
- ready rises the cycle after the hold→shift transfer. The producer therefore has a full frame minus one cycle to present the next byte without creating a gap.
- busy is high from the START edge until the edge that returns to IDLE.
- Reset values:
  - out = 1, busy = 0, done = 0.
  - ready = 0 during reset; ready = 1 on the first cycle after resetn rises.

## Test plan
- **Reset:** hold resetn low 2 cycles with valid = 1 → out = 1, busy = 0, done = 0, ready = 0, and no byte captured. After release: ready = 1 and out stays 1.
- **Single byte:** send 0xA5 at edge N (STOP_BITS = 1).
  - out from edge N+1 is 0,1,0,1,0,0,1,0,1,1.
  - busy is high for 10 cycles.
  - done is high only during the N+10 cycle.
  - Returns to IDLE at N+11.
- **Back-to-back:** send 0x00 then 0xFF, with valid held and each byte offered as soon as ready.
  - out shows 0,00000000,1 then immediately 0,11111111,1, with no idle cycle between frames.
  - ready is low from the second accept until the second frame's START edge.
- **STOP_BITS = 2:** send 0x3C → 11-cycle frame: 0,0,0,1,1,1,1,0,0,1,1. done is high only on the second stop-bit cycle.
- **Reset mid-frame:** send 0x81, then queue 0x55 in hold; pull resetn low during data bit 4.
  - Next edge: out = 1, busy = 0, ready = 0.
  - After release, 0x55 is not sent.
  - A fresh 0x5A is transmitted correctly: 0,0,1,0,1,1,0,1,0,1.
- **Stall:** keep valid high with changing in_byte while hold is full → only the byte present at the handshake edge is transmitted, and intermediate values never appear on out.
